// File: rtl/exec_controller.sv
// exec_controller
// Run/halt/single-step controller for a single-cycle RV32 core. Gates the PC
// register load and the register-file write enable, detects program termination
// (branch-to-self or an exhausted instruction budget) and keeps saturating cycle
// and retired-instruction counters.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous active-high reset
//   i_start          begin free-running execution (from IDLE)
//   i_stop           return to IDLE after the current commit (from RUN)
//   i_step           execute exactly one instruction (from IDLE)
//   i_clear          leave HALT, zero counters and halt information
//   i_pc             current PC
//   i_next_pc        PC value the PC register would load this cycle
//   i_reg_write_req  RegWrite from the control decoder
//   o_pc_en          PC register load enable (a "commit" cycle)
//   o_reg_we         gated register-file write enable
//   o_running        state is RUN
//   o_halted         state is HALT
//   o_halt_cause     bit0 self-loop, bit1 budget reached
//   o_halt_pc        PC of the instruction that caused HALT
//   o_cycle_count    cycles spent outside HALT since reset/clear
//   o_instr_count    committed instructions since reset/clear
module exec_controller #(
    parameter int unsigned DW        = 32,
    parameter int unsigned CW        = 32,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_step,
    input  logic          i_clear,
    input  logic [DW-1:0] i_pc,
    input  logic [DW-1:0] i_next_pc,
    input  logic          i_reg_write_req,
    output logic          o_pc_en,
    output logic          o_reg_we,
    output logic          o_running,
    output logic          o_halted,
    output logic [1:0]    o_halt_cause,
    output logic [DW-1:0] o_halt_pc,
    output logic [CW-1:0] o_cycle_count,
    output logic [CW-1:0] o_instr_count
);

    typedef enum logic [1:0] {StIdle, StRun, StStep, StHalt} state_e;

    // Budget compared on 64 bits so instr_count+1 can never wrap back onto it.
    localparam logic [63:0] MaxInstr = 64'(MAX_INSTR);
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    state_e        r_state;
    logic          r_pc_en;
    logic          r_running;
    logic          r_halted;
    logic [1:0]    r_halt_cause;
    logic [DW-1:0] r_halt_pc;
    logic [CW-1:0] r_cycle_count;
    logic [CW-1:0] r_instr_count;

    logic          w_commit;
    logic          w_selfloop;
    logic          w_budget;
    logic          w_halt;
    logic [63:0]   w_instr_inc;

    // pc_en is registered alongside the state, so it is exactly state==RUN||STEP.
    assign w_commit    = r_pc_en;
    assign w_instr_inc = 64'(r_instr_count) + 64'd1;
    assign w_selfloop  = w_commit && (i_next_pc == i_pc);
    assign w_budget    = w_commit && (MAX_INSTR != 0) && (w_instr_inc == MaxInstr);
    assign w_halt      = w_selfloop || w_budget;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_pc_en       <= 1'b0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_halt_cause  <= 2'b00;
            r_halt_pc     <= '0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else if (i_clear) begin
            // clear beats any halt condition in the same cycle
            r_state       <= StIdle;
            r_pc_en       <= 1'b0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_halt_cause  <= 2'b00;
            r_halt_pc     <= '0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state != StHalt && r_cycle_count != CntMax) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_commit && r_instr_count != CntMax) begin
                r_instr_count <= r_instr_count + 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state   <= StRun;
                        r_pc_en   <= 1'b1;
                        r_running <= 1'b1;
                    end else if (i_step) begin
                        r_state <= StStep;
                        r_pc_en <= 1'b1;
                    end
                end
                StRun, StStep: begin
                    if (w_halt) begin
                        r_state      <= StHalt;
                        r_pc_en      <= 1'b0;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                        r_halt_pc    <= i_pc;
                        r_halt_cause <= {w_budget, w_selfloop};
                    end else if (r_state == StStep || i_stop) begin
                        // a step always returns to IDLE after its single commit
                        r_state   <= StIdle;
                        r_pc_en   <= 1'b0;
                        r_running <= 1'b0;
                    end
                end
                StHalt: begin
                    // only clear (handled above) leaves HALT
                end
                default: begin
                    r_state   <= StIdle;
                    r_pc_en   <= 1'b0;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc_en       = r_pc_en;
    assign o_reg_we      = r_pc_en && i_reg_write_req;
    assign o_running     = r_running;
    assign o_halted      = r_halted;
    assign o_halt_cause  = r_halt_cause;
    assign o_halt_pc     = r_halt_pc;
    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller. Three instances run side by side:
// u0 (CW=32, no budget), u1 (MAX_INSTR=3) and u2 (CW=4, saturation). Each has
// its own small core model (PC register plus a0) feeding pc/next_pc, and a
// behavioural model of the controller that is compared every cycle.
module tb_exec_controller;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic step = 1'b0;
    logic clear = 1'b0;

    logic [31:0] pc_in  [NI];
    logic [31:0] nxt_in [NI];
    logic        rw_in  [NI];

    logic        a_pc_en  [NI];
    logic        a_reg_we [NI];
    logic        a_run    [NI];
    logic        a_halt   [NI];
    logic [1:0]  a_cause  [NI];
    logic [31:0] a_hpc    [NI];
    logic [31:0] cc0, cc1, ic0, ic1;
    logic [3:0]  cc2, ic2;
    logic [63:0] a_cc [NI];
    logic [63:0] a_ic [NI];

    assign a_cc[0] = 64'(cc0);
    assign a_cc[1] = 64'(cc1);
    assign a_cc[2] = 64'(cc2);
    assign a_ic[0] = 64'(ic0);
    assign a_ic[1] = 64'(ic1);
    assign a_ic[2] = 64'(ic2);

    exec_controller #(.DW(32), .CW(32), .MAX_INSTR(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_clear(clear), .i_pc(pc_in[0]), .i_next_pc(nxt_in[0]),
        .i_reg_write_req(rw_in[0]), .o_pc_en(a_pc_en[0]), .o_reg_we(a_reg_we[0]),
        .o_running(a_run[0]), .o_halted(a_halt[0]), .o_halt_cause(a_cause[0]),
        .o_halt_pc(a_hpc[0]), .o_cycle_count(cc0), .o_instr_count(ic0)
    );
    exec_controller #(.DW(32), .CW(32), .MAX_INSTR(3)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_clear(clear), .i_pc(pc_in[1]), .i_next_pc(nxt_in[1]),
        .i_reg_write_req(rw_in[1]), .o_pc_en(a_pc_en[1]), .o_reg_we(a_reg_we[1]),
        .o_running(a_run[1]), .o_halted(a_halt[1]), .o_halt_cause(a_cause[1]),
        .o_halt_pc(a_hpc[1]), .o_cycle_count(cc1), .o_instr_count(ic1)
    );
    exec_controller #(.DW(32), .CW(4), .MAX_INSTR(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_step(step),
        .i_clear(clear), .i_pc(pc_in[2]), .i_next_pc(nxt_in[2]),
        .i_reg_write_req(rw_in[2]), .o_pc_en(a_pc_en[2]), .o_reg_we(a_reg_we[2]),
        .o_running(a_run[2]), .o_halted(a_halt[2]), .o_halt_cause(a_cause[2]),
        .o_halt_pc(a_hpc[2]), .o_cycle_count(cc2), .o_instr_count(ic2)
    );

    function automatic int unsigned max_instr_of(int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic logic [63:0] cnt_max_of(int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    // Test program: a0=5; loop: a0--; bne a0,x0,loop; two addi; beq x0,x0,0 at 0x14.
    // Any other address is straight-line addi code.
    function automatic logic [31:0] prog_next(logic [31:0] pc, logic [31:0] a0);
        case (pc)
            32'h08:  return (a0 != 0) ? 32'h04 : 32'h0C;
            32'h14:  return 32'h14;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic prog_rw(logic [31:0] pc);
        return !(pc == 32'h08 || pc == 32'h14);
    endfunction

    // ---------------- core + controller model ----------------
    localparam int MIdle = 0, MRun = 1, MStep = 2, MHalt = 3;

    logic        prog_mode = 1'b1;
    logic        load_en = 1'b0;
    logic [31:0] load_pc = '0;
    logic [31:0] core_pc [NI];
    logic [31:0] core_a0 [NI];
    logic [31:0] rnd_next [NI];
    logic        rnd_rw [NI];

    int          m_st    [NI];
    logic [63:0] m_cc    [NI];
    logic [63:0] m_ic    [NI];
    logic [1:0]  m_cause [NI];
    logic [31:0] m_hpc   [NI];
    logic        mc, msl, mbd;

    initial begin
        for (int k = 0; k < NI; k++) begin
            core_pc[k]  = '0;
            core_a0[k]  = '0;
            rnd_next[k] = 32'd4;
            rnd_rw[k]   = 1'b0;
            m_st[k]     = MIdle;
            m_cc[k]     = '0;
            m_ic[k]     = '0;
            m_cause[k]  = '0;
            m_hpc[k]    = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            pc_in[k]  = core_pc[k];
            nxt_in[k] = prog_mode ? prog_next(core_pc[k], core_a0[k]) : rnd_next[k];
            rw_in[k]  = prog_mode ? prog_rw(core_pc[k]) : rnd_rw[k];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            mc  = (m_st[k] == MRun) || (m_st[k] == MStep);
            msl = mc && (nxt_in[k] == pc_in[k]);
            mbd = mc && (max_instr_of(k) != 0) && (m_ic[k] + 64'd1 == 64'(max_instr_of(k)));
            if (rst || clear) begin
                m_st[k] = MIdle; m_cc[k] = '0; m_ic[k] = '0; m_cause[k] = '0; m_hpc[k] = '0;
            end else begin
                if (m_st[k] != MHalt && m_cc[k] < cnt_max_of(k)) m_cc[k] = m_cc[k] + 1;
                if (mc && m_ic[k] < cnt_max_of(k)) m_ic[k] = m_ic[k] + 1;
                if (mc && (msl || mbd)) begin
                    m_st[k] = MHalt; m_hpc[k] = pc_in[k]; m_cause[k] = {mbd, msl};
                end else if (m_st[k] == MIdle) begin
                    if (start) m_st[k] = MRun;
                    else if (step) m_st[k] = MStep;
                end else if (m_st[k] == MStep) begin
                    m_st[k] = MIdle;
                end else if (m_st[k] == MRun && stop) begin
                    m_st[k] = MIdle;
                end
            end
            // the core itself: PC and a0 move on every cycle with pc_en high
            if (mc) begin
                if (prog_mode && pc_in[k] == 32'h00) core_a0[k] = 32'd5;
                if (prog_mode && pc_in[k] == 32'h04) core_a0[k] = core_a0[k] - 1;
                core_pc[k] = nxt_in[k];
            end
            if (load_en) begin
                core_pc[k] = load_pc;
                core_a0[k] = '0;
            end
            case ($urandom_range(0, 7))
                0:       rnd_next[k] = core_pc[k];
                1:       rnd_next[k] = $urandom & 32'hFFFF_FFFC;
                default: rnd_next[k] = core_pc[k] + 32'd4;
            endcase
            rnd_rw[k] = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- checking ----------------
    int n_err = 0;
    int n_chk = 0;
    logic chk_en = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic pe;
        for (int k = 0; k < NI; k++) begin
            pe = (m_st[k] == MRun) || (m_st[k] == MStep);
            chk($sformatf("u%0d.pc_en", k), 64'(a_pc_en[k]), 64'(pe));
            chk($sformatf("u%0d.reg_we", k), 64'(a_reg_we[k]), 64'(pe && rw_in[k]));
            chk($sformatf("u%0d.running", k), 64'(a_run[k]), 64'(m_st[k] == MRun));
            chk($sformatf("u%0d.halted", k), 64'(a_halt[k]), 64'(m_st[k] == MHalt));
            chk($sformatf("u%0d.halt_cause", k), 64'(a_cause[k]), 64'(m_cause[k]));
            chk($sformatf("u%0d.halt_pc", k), 64'(a_hpc[k]), 64'(m_hpc[k]));
            chk($sformatf("u%0d.cycle_count", k), a_cc[k], m_cc[k]);
            chk($sformatf("u%0d.instr_count", k), a_ic[k], m_ic[k]);
        end
    endtask

    // Advance one clock; inputs change and outputs are checked 2 units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
        if (chk_en) compare_all();
    endtask

    task automatic load(logic [31:0] pc);
        load_pc = pc;
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
    endtask

    initial begin
        bit done;

        // reset
        rst = 1'b1;
        load(32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset.pc_en", 64'(a_pc_en[0]), 64'd0);
        chk("reset.running", 64'(a_run[0]), 64'd0);
        chk("reset.halted", 64'(a_halt[0]), 64'd0);
        chk("reset.halt_cause", 64'(a_cause[0]), 64'd0);
        chk("reset.instr_count", a_ic[0], 64'd0);

        // program with self-loop at 0x14 (u1 stops on its 3-instruction budget)
        start = 1'b1;
        cyc();
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            done = a_halt[0];
        end
        chk("selfloop.halted_in_time", 64'(done), 64'd1);
        chk("selfloop.halt_cause", 64'(a_cause[0]), 64'd1);
        chk("selfloop.halt_pc", 64'(a_hpc[0]), 64'h14);
        chk("selfloop.instr_count", a_ic[0], 64'd14);
        chk("budget.halt_cause", 64'(a_cause[1]), 64'd2);
        chk("budget.halt_pc", 64'(a_hpc[1]), 64'h08);
        chk("budget.instr_count", a_ic[1], 64'd3);
        repeat (3) cyc();
        chk("selfloop.pc_en_after", 64'(a_pc_en[0]), 64'd0);
        chk("selfloop.instr_count_after", a_ic[0], 64'd14);

        // single step, 4 pulses 3 idle cycles apart
        clear = 1'b1;
        load(32'h100);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            chk("step.pulse", 64'(a_pc_en[0]), 64'd1);
            repeat (3) cyc();
            chk("step.idle", 64'(a_pc_en[0]), 64'd0);
        end
        chk("step.instr_count", a_ic[0], 64'd4);
        chk("step.budget_halt_pc", 64'(a_hpc[1]), 64'h108);

        // stop at the 10th RUN cycle, then resume
        clear = 1'b1;
        load(32'h200);
        clear = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop.instr_count", a_ic[0], 64'd10);
        chk("stop.pc_en", 64'(a_pc_en[0]), 64'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("resume.instr_count", a_ic[0], 64'd11);

        // rst in the middle of RUN
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst.pc_en", 64'(a_pc_en[0]), 64'd0);
        chk("rst.cycle_count", a_cc[0], 64'd0);
        chk("rst.instr_count", a_ic[0], 64'd0);

        // clear coincident with a self-loop commit
        load(32'h14);
        start = 1'b1;
        cyc();
        start = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_vs_halt.halted", 64'(a_halt[0]), 64'd0);
        chk("clear_vs_halt.halt_cause", 64'(a_cause[0]), 64'd0);
        chk("clear_vs_halt.instr_count", a_ic[0], 64'd0);

        // saturation on the 4-bit counters
        clear = 1'b1;
        load(32'h300);
        clear = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        chk("sat.cycle_count", a_cc[2], 64'd15);
        chk("sat.instr_count", a_ic[2], 64'd15);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // randomized control and next_pc
        prog_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            step  = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 23) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            cyc();
        end
        start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0; rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
